// File: rtl/automaton_frame_writer_pkg.sv
// rtl/automaton_frame_writer_pkg.sv - shared constants and FSM state type for the automaton frame writer
package automaton_pkg;
    localparam int WORD_W        = 20;
    localparam int WORDS_PER_ROW = 64;
    localparam int ROWS          = 1024;
    localparam int ADDR_W        = 16;
    localparam int SEED_WORD     = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEED,
        ST_GEN,
        ST_DONE
    } writer_state_t;
endpackage

// File: rtl/automaton_frame_writer_if.sv
// rtl/automaton_frame_writer_if.sv - frame RAM port A bundle (shared read/write address)
interface automaton_frame_writer_if;
    import automaton_pkg::*;

    logic [ADDR_W-1:0] address_a;
    logic [WORD_W-1:0] data_a;
    logic              wren_a;
    logic [WORD_W-1:0] q_a;

    modport master (output address_a, output data_a, output wren_a, input q_a);
    modport slave  (input address_a, input data_a, input wren_a, output q_a);
endinterface

// File: rtl/automaton_frame_writer_ca_word_next.sv
// rtl/automaton_frame_writer_ca_word_next.sv - next-generation word of an elementary cellular automaton
module ca_word_next
    import automaton_pkg::*;
(
    input  logic [7:0]        rule_i,
    input  logic              lbit_i,
    input  logic [WORD_W-1:0] cur_i,
    input  logic              rbit_i,
    output logic [WORD_W-1:0] next_o
);
    // ext[b] is the left neighbour of cur bit b, ext[b+2] its right neighbour
    logic [WORD_W+1:0] ext;
    assign ext = {rbit_i, cur_i, lbit_i};

    always_comb begin
        next_o = '0;
        for (int b = 0; b < WORD_W; b++) begin
            next_o[b] = rule_i[{ext[b], ext[b+1], ext[b+2]}];
        end
    end
endmodule

// File: rtl/automaton_frame_writer.sv
// rtl/automaton_frame_writer.sv - seeds row 0 then computes rows 1..1023 by read-back through RAM port A
module automaton_frame_writer
    import automaton_pkg::*;
(
    input  logic                             clk108,
    input  logic                             reset,
    input  logic                             start,
    input  logic [7:0]                       rule,
    automaton_frame_writer_if.master         ram,
    output logic                             busy,
    output logic                             done
);
    localparam logic [9:0] ROW_LAST  = 10'(ROWS - 1);
    localparam logic [6:0] STEP_LAST = 7'(WORDS_PER_ROW);

    writer_state_t     state_q, state_d;
    logic [9:0]        row_q, row_d;
    logic [6:0]        step_q, step_d;
    logic              phase_q, phase_d;
    logic [WORD_W-1:0] cur_q, cur_d;
    logic              lbit_q, lbit_d;
    logic [7:0]        rule_q, rule_d;

    logic              rbit;
    logic [WORD_W-1:0] next_word;

    // Beyond the last word of the row the right neighbour is the zero boundary
    assign rbit = (step_q == STEP_LAST) ? 1'b0 : ram.q_a[0];

    ca_word_next u_next (
        .rule_i (rule_q),
        .lbit_i (lbit_q),
        .cur_i  (cur_q),
        .rbit_i (rbit),
        .next_o (next_word)
    );

    always_ff @(posedge clk108) begin
        if (reset) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            step_q  <= '0;
            phase_q <= 1'b0;
            cur_q   <= '0;
            lbit_q  <= 1'b0;
            rule_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            step_q  <= step_d;
            phase_q <= phase_d;
            cur_q   <= cur_d;
            lbit_q  <= lbit_d;
            rule_q  <= rule_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        step_d        = step_q;
        phase_d       = phase_q;
        cur_d         = cur_q;
        lbit_d        = lbit_q;
        rule_d        = rule_q;
        ram.address_a = '0;
        ram.data_a    = '0;
        ram.wren_a    = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rule_d  = rule;
                    step_d  = '0;
                    state_d = ST_SEED;
                end
            end
            ST_SEED: begin
                busy          = 1'b1;
                ram.wren_a    = 1'b1;
                ram.address_a = {10'd0, step_q[5:0]};
                ram.data_a    = (step_q == 7'(SEED_WORD)) ? WORD_W'(1) : '0;
                if (step_q == STEP_LAST - 7'd1) begin
                    state_d = ST_GEN;
                    row_d   = 10'd1;
                    step_d  = '0;
                    phase_d = 1'b0;
                    cur_d   = '0;
                    lbit_d  = 1'b0;
                end else begin
                    step_d = step_q + 7'd1;
                end
            end
            ST_GEN: begin
                busy = 1'b1;
                if (!phase_q) begin
                    ram.address_a = {row_q - 10'd1, step_q[5:0]};
                    phase_d       = 1'b1;
                end else begin
                    // Step j writes word j-1 once word j of the row above is on q_a
                    if (step_q != 7'd0) begin
                        ram.wren_a    = 1'b1;
                        ram.address_a = {row_q, 6'(step_q - 7'd1)};
                        ram.data_a    = next_word;
                    end
                    phase_d = 1'b0;
                    if (step_q == STEP_LAST) begin
                        step_d = '0;
                        cur_d  = '0;
                        lbit_d = 1'b0;
                        if (row_q == ROW_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            row_d = row_q + 10'd1;
                        end
                    end else begin
                        step_d = step_q + 7'd1;
                        lbit_d = cur_q[WORD_W-1];
                        cur_d  = ram.q_a;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_automaton_frame_writer.sv
// tb/tb_automaton_frame_writer.sv - frame writer bench with behavioural RAM and pixel-level automaton model
module tb_automaton_frame_writer;
    localparam int FRAME_LAST_WRITE = 133054;
    localparam int FRAME_DONE       = 133055;

    logic       clk108 = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] rule;
    logic       busy;
    logic       done;

    automaton_frame_writer_if bus ();

    automaton_frame_writer dut (
        .clk108 (clk108),
        .reset  (reset),
        .start  (start),
        .rule   (rule),
        .ram    (bus),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk108 = ~clk108;

    logic [19:0] mem [0:65535];
    always @(posedge clk108) begin
        if (bus.wren_a) mem[bus.address_a] <= bus.data_a;
        bus.q_a <= mem[bus.address_a];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    // Reference image: one bit per pixel, pixel x at index x
    bit [1279:0] img [0:1023];

    task automatic build_model(input logic [7:0] rl);
        bit l, c, r;
        img[0] = '0;
        img[0][640] = 1'b1;
        for (int y = 1; y < 1024; y++) begin
            for (int x = 0; x < 1280; x++) begin
                l = (x > 0)    ? img[y-1][x-1] : 1'b0;
                c = img[y-1][x];
                r = (x < 1279) ? img[y-1][x+1] : 1'b0;
                img[y][x] = rl[{l, c, r}];
            end
        end
    endtask

    function automatic logic [19:0] model_word(input int y, input int w);
        return img[y][20*w +: 20];
    endfunction

    typedef struct {
        logic [7:0]  rl;
        int          row;
        int          word;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl [17];

    task automatic run_frame(input logic [7:0] rl, input int rst_at);
        int   errs, ndone, nbusy, done_cycle, extra, nwr;
        logic ew;
        logic [15:0] ea;
        logic [19:0] ed;
        int   m, r, t, k;
        build_model(rl);
        errs = 0; ndone = 0; nbusy = 0; done_cycle = -1;
        extra = $urandom_range(100, 130000);
        @(negedge clk108);
        start = 1'b1;
        rule  = rl;
        @(posedge clk108);
        #1;
        start = 1'b0;
        rule  = 8'($urandom);
        for (int n = 1; n <= FRAME_DONE + 1; n++) begin
            @(negedge clk108);
            ew = 1'b0; ea = '0; ed = '0;
            if (n <= 64) begin
                ew = 1'b1; ea = 16'(n - 1); ed = model_word(0, n - 1);
            end else if (n <= FRAME_LAST_WRITE) begin
                m = n - 65; r = m / 130 + 1; t = m % 130;
                if (t >= 3 && (t % 2) == 1) begin
                    k = (t - 3) / 2;
                    ew = 1'b1; ea = 16'(r * 64 + k); ed = model_word(r, k);
                end
            end
            if (bus.wren_a !== ew || (ew && (bus.address_a !== ea || bus.data_a !== ed))) begin
                if (errs < 4)
                    $display("write diff at cycle %0d: we=%0b a=%0h d=%0h expected we=%0b a=%0h d=%0h",
                             n, bus.wren_a, bus.address_a, bus.data_a, ew, ea, ed);
                errs++;
            end
            if (busy === 1'b1) nbusy++;
            if (busy !== ((n <= FRAME_LAST_WRITE) ? 1'b1 : 1'b0)) errs++;
            if (done === 1'b1) begin ndone++; done_cycle = n; end
            start = (n == 5 || n == 70000 || n == extra) ? 1'b1 : 1'b0;
            if (n == rst_at) begin
                reset = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check("write_stream", errs, 0);
        if (rst_at > 0) begin
            @(negedge clk108);
            check("post_reset_outputs", {bus.wren_a, busy, done}, 3'b000);
            reset = 1'b0;
            nwr = 0;
            for (int n = 0; n < 300; n++) begin
                @(negedge clk108);
                if (bus.wren_a || busy || done) nwr++;
            end
            check("quiet_after_reset", nwr, 0);
            check("partial_seed_kept", mem[32], 20'h00001);
        end else begin
            check("done_count", ndone, 1);
            check("done_cycle", done_cycle, FRAME_DONE);
            check("busy_cycles", nbusy, FRAME_LAST_WRITE);
            errs = 0;
            for (int y = 0; y < 1024; y++)
                for (int w = 0; w < 64; w++)
                    if (mem[y*64 + w] !== model_word(y, w)) errs++;
            check("ram_vs_model", errs, 0);
            foreach (tbl[i])
                if (tbl[i].rl == rl)
                    check($sformatf("ram_r%0d_w%0d_rule%0d", tbl[i].row, tbl[i].word, rl),
                          mem[tbl[i].row*64 + tbl[i].word], tbl[i].exp);
        end
    endtask

    function automatic int nonzero_rows(input int first);
        int cnt = 0;
        for (int a = first * 64; a < 65536; a++)
            if (mem[a] !== 20'h0) cnt++;
        return cnt;
    endfunction

    initial begin
        tbl = '{
            '{8'd204, 0,    32, 20'h00001}, '{8'd204, 0,    0,  20'h00000},
            '{8'd204, 700,  32, 20'h00001}, '{8'd204, 1023, 32, 20'h00001},
            '{8'd204, 1023, 63, 20'h00000},
            '{8'd90,  1,    31, 20'h80000}, '{8'd90,  1,    32, 20'h00002},
            '{8'd90,  1,    30, 20'h00000}, '{8'd90,  2,    31, 20'h40000},
            '{8'd90,  2,    32, 20'h00004},
            '{8'd170, 20,   31, 20'h00001}, '{8'd170, 640,  0,  20'h00001},
            '{8'd170, 639,  0,  20'h00002}, '{8'd170, 1,    31, 20'h80000},
            '{8'd240, 639,  63, 20'h80000}, '{8'd240, 1,    32, 20'h00002},
            '{8'd240, 640,  0,  20'h00000}
        };
        for (int a = 0; a < 65536; a++) mem[a] = 20'($urandom);
        reset = 1'b1;
        start = 1'b0;
        rule  = '0;
        repeat (3) @(posedge clk108);
        @(negedge clk108);
        check("reset_outputs", {bus.wren_a, bus.address_a, bus.data_a, busy, done}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk108);

        run_frame(8'd204, 0);
        run_frame(8'd90, 0);
        run_frame(8'($urandom), 5000);
        run_frame(8'd170, 0);
        check("rule170_rows_641_up_zero", nonzero_rows(641), 0);
        run_frame(8'd240, 0);
        check("rule240_rows_640_up_zero", nonzero_rows(640), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
